usr_deser_8bit: RTL

Serial-to-parallel receiver for the far end of the universal shift register's serial path. It accepts one bit per handshake, LSB-first (source shifting right) or MSB-first (source shifting left). After WIDTH bits it presents the reassembled word on a registered valid/ready output port. Backpressure stalls the serial side, and a mid-frame restart is flagged.

---
 rtl/usr_deser_8bit_if.sv | 28 ++
 rtl/usr_deser_8bit.sv | 103 ++++++++++
 2 files changed

// File: rtl/usr_deser_8bit_if.sv
// Serial-in / parallel-out bus for usr_deser_8bit. The slave modport is the receiver side,
// and the master modport is the bit source plus the word consumer.
interface usr_deser_8bit_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             s_valid;
  logic             s_data;
  logic             s_start;
  logic             s_dir;
  logic             s_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             frame_err;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output s_valid, s_data, s_start, s_dir, m_ready,
    input  s_ready, m_data, m_valid, frame_err, bit_cnt
  );

  modport slave (
    input  s_valid, s_data, s_start, s_dir, m_ready,
    output s_ready, m_data, m_valid, frame_err, bit_cnt
  );
endinterface

// File: rtl/usr_deser_8bit.sv
// Serial-to-parallel receiver. It collects WIDTH bits LSB- or MSB-first into a word.
// The word is presented on a registered valid/ready port, and a mid-frame restart is flagged.
module usr_deser_8bit #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  usr_deser_8bit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] m_data_q;
  logic             m_valid_q;
  logic             frame_err_q;
  logic [CW-1:0]    bit_cnt_q;
  logic             dir_q;
  logic             shift_dir;
  logic             accept;
  logic             draining;
  logic             last_bit;

  assign bus.s_ready   = (state != FULL);
  assign bus.m_data    = m_data_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.bit_cnt   = bit_cnt_q;

  assign accept   = bus.s_valid && bus.s_ready;
  assign draining = m_valid_q && bus.m_ready;
  assign last_bit = (bit_cnt_q == CW'(WIDTH - 1));

  // A start bit shifts with the direction it brings, not the one latched for the old frame.
  assign shift_dir = (state == SHIFT && !bus.s_start) ? dir_q : bus.s_dir;
  assign shifted   = shift_dir ? {shreg[WIDTH-2:0], bus.s_data}
                               : {bus.s_data, shreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt_q   <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (draining)
        m_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (accept && bus.s_start) begin
            dir_q     <= bus.s_dir;
            shreg     <= shifted;
            bit_cnt_q <= CW'(1);
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (accept) begin
            if (bus.s_start) begin
              frame_err_q <= 1'b1;
              dir_q       <= bus.s_dir;
              shreg       <= shifted;
              bit_cnt_q   <= CW'(1);
            end else if (last_bit) begin
              bit_cnt_q <= '0;
              // Park the word in shreg when the output slot cannot take it this cycle.
              if (!m_valid_q || draining) begin
                m_data_q  <= shifted;
                m_valid_q <= 1'b1;
                state     <= IDLE;
              end else begin
                shreg <= shifted;
                state <= FULL;
              end
            end else begin
              shreg     <= shifted;
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end

        FULL: begin
          if (draining) begin
            m_data_q  <= shreg;
            m_valid_q <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
